sweep_ctrl: RTL
===============

Name: sweep_ctrl

Overview:
- Control stage directly upstream of the 8-bit up/down counter; drives its enable and direction inputs.
- Makes the counter sweep back and forth (ping-pong) between programmable low and high bounds.
- Paces steps with a programmable prescaler and counts completed round trips.
- Reads the counter's output back on count_in to decide when to turn.

Parameters:
- WIDTH, 8, width of bounds and of count_in.
- PRE_W, 8, width of prescale input and internal prescale counter.
- RND_W, 4, width of num_sweeps and sweep_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin sweeping; honoured only in IDLE.
- stop  in  1  abort request; honoured in UP/DOWN.
- lo_bound  in  WIDTH  lower turn point, sampled on accepted start.
- hi_bound  in  WIDTH  upper turn point, sampled on accepted start.
- prescale  in  PRE_W  one step every prescale+1 cycles, sampled on accepted start.
- num_sweeps  in  RND_W  round trips to perform; 0 = run until stop; sampled on accepted start.
- count_in  in  WIDTH  current counter value, fed back from the counter output.
- enable  out  1  step request to counter (combinational).
- direction  out  1  1 = count up, 0 = count down (registered).
- busy  out  1  high in UP or DOWN.
- done  out  1  one-cycle pulse on completing num_sweeps rounds.
- err  out  1  one-cycle pulse on a start rejected for bad bounds.
- sweep_cnt  out  RND_W  completed round trips since last accepted start.

Behaviour:
- States: IDLE, UP, DOWN. Reset gives IDLE, direction=1, busy=0, done=0, err=0, sweep_cnt=0, prescale counter=0; enable=0 while rst high.
- IDLE + start + !stop + lo_bound<hi_bound: latch lo/hi/prescale/num_sweeps, clear sweep_cnt and prescale counter, go UP next cycle.
- IDLE + start + lo_bound>=hi_bound: stay IDLE, err=1 next cycle for one cycle.
- IDLE + start + stop: stay IDLE, no err.
- Prescaler: pre_cnt counts 0..prescale in UP/DOWN and wraps to 0. tick = (pre_cnt==prescale). prescale=0 gives tick every cycle.
- direction = 1 in UP, 0 in DOWN; holds its last value in IDLE.
- enable = busy & tick & !stop & !at_bound.
  - at_bound in UP: count_in>=hi_latched.
  - at_bound in DOWN: count_in<=lo_latched.
  - Counter updates at the end of the enable cycle, so count_in is valid for the next decision; no pipeline hazard.
- UP, tick, at_bound: go DOWN; no enable that tick.
- DOWN, tick, at_bound (round complete): sweep_cnt+1, wrapping at 2^RND_W.
  - If num_sweeps!=0 and the new sweep_cnt==num_sweeps: go IDLE, done=1 next cycle for one cycle.
  - Otherwise: go UP.
- count_in below lo in UP, or above hi in DOWN: keep stepping normally; there is no special handling.
- stop in UP/DOWN: go IDLE next cycle, enable=0 in the stop cycle, no done. stop has priority over tick and over round completion.
- start while busy: ignored.
- rst mid-operation: returns to reset values at that edge; enable low during rst.
- Wrap-around of count_in is impossible while the bounds are respected, because the block never steps past them.

Test Plan:
- All tests use a behavioural counter model, reset to 0, fed back on count_in.
- Single round: lo=2, hi=5, prescale=0, num_sweeps=1, start in cycle 0.
  - enable high cycles 1-5 (count 0->5); cycle 6 turn, no enable; direction=0 from cycle 7.
  - enable cycles 7-9 (5->2); cycle 10 completes.
  - done=1 and busy=0 in cycle 11; sweep_cnt=1.
- Prescale: prescale=3, lo=0, hi=10 -> enable pulses exactly every 4th cycle; count reaches 10 after 40 cycles.
- Stop: lo=0, hi=20, prescale=0, stop asserted with count_in=7 in UP -> enable=0 that cycle, IDLE next cycle, count stays 7, done never asserted.
- Bad bounds: start with lo=9, hi=9 -> err one-cycle pulse, busy stays 0, enable stays 0.
- Continuous with wrap: num_sweeps=0, lo=0, hi=1 -> sweep_cnt counts 1..15,0,1…; done never pulses; stop ends the run.
- Reset mid-run: rst high while in DOWN with count_in=3 -> next cycle IDLE, direction=1, sweep_cnt=0, enable=0; a new start then works normally.

Source files
------------

// File: rtl/sweep_ctrl_if.sv
// Handshake and data bundle between the sweep controller and its surroundings:
// run control, sweep programming, counter feedback and status outputs.
interface sweep_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8,
  parameter int RND_W = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] lo_bound;
  logic [WIDTH-1:0] hi_bound;
  logic [PRE_W-1:0] prescale;
  logic [RND_W-1:0] num_sweeps;
  logic [WIDTH-1:0] count_in;
  logic             enable;
  logic             direction;
  logic             busy;
  logic             done;
  logic             err;
  logic [RND_W-1:0] sweep_cnt;

  // Side that programs the sweep and owns the counter
  modport master (
    output start, stop, lo_bound, hi_bound, prescale, num_sweeps, count_in,
    input  enable, direction, busy, done, err, sweep_cnt
  );

  // Sweep controller side
  modport slave (
    input  start, stop, lo_bound, hi_bound, prescale, num_sweeps, count_in,
    output enable, direction, busy, done, err, sweep_cnt
  );
endinterface

// File: rtl/sweep_ctrl.sv
// Ping-pong sweep controller for an up/down counter: steps the counter between
// latched low/high bounds at a prescaled rate and counts completed round trips.
module sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8,
  parameter int RND_W = 4
) (
  input logic        clk,
  input logic        rst,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [RND_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  // Sweep programming captured on an accepted start; never reset
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [RND_W-1:0] num_q, num_d;

  logic             busy;
  logic             tick;
  logic             at_bound;
  logic             step_en;
  logic [RND_W-1:0] sweep_next;

  // Round counter advance; wraps naturally at 2^RND_W
  function automatic logic [RND_W-1:0] round_inc(input logic [RND_W-1:0] v);
    return v + 1'b1;
  endfunction

  // Status decode and the combinational step request
  always_comb begin
    busy       = (state_q != IDLE);
    tick       = (pre_cnt_q == pre_q);
    at_bound   = (state_q == UP) ? (bus.count_in >= hi_q) : (bus.count_in <= lo_q);
    step_en    = busy & tick & ~bus.stop & ~at_bound & ~rst;
    sweep_next = round_inc(sweep_cnt_q);
  end

  assign bus.enable    = step_en;
  assign bus.direction = dir_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sweep_cnt = sweep_cnt_q;

  // Next-state logic: start acceptance, prescaler, turn points and stop
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sweep_cnt_d = sweep_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    pre_d       = pre_q;
    num_d       = num_q;

    case (state_q)
      IDLE: begin
        pre_cnt_d = '0;
        // A simultaneous stop cancels the start outright, without flagging err
        if (bus.start && !bus.stop) begin
          if (bus.lo_bound < bus.hi_bound) begin
            lo_d        = bus.lo_bound;
            hi_d        = bus.hi_bound;
            pre_d       = bus.prescale;
            num_d       = bus.num_sweeps;
            sweep_cnt_d = '0;
            dir_d       = 1'b1;
            state_d     = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      UP, DOWN: begin
        if (bus.stop) begin
          // Stop outranks both the tick and a round completion
          state_d   = IDLE;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
          if (tick && at_bound) begin
            if (state_q == UP) begin
              state_d = DOWN;
              dir_d   = 1'b0;
            end else begin
              sweep_cnt_d = sweep_next;
              if ((num_q != '0) && (sweep_next == num_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = UP;
                dir_d   = 1'b1;
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers: control is reset, latched programming is not
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sweep_cnt_q <= '0;
      pre_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sweep_cnt_q <= sweep_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
    end
    lo_q  <= lo_d;
    hi_q  <= hi_d;
    pre_q <= pre_d;
    num_q <= num_d;
  end

endmodule
